multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit CPU. It replaces single-cycle opcode decode with a FETCH/DECODE/EXEC/MEM/WB sequence.
- Handshakes with instruction and data memories that have variable latency. Drives PC, instruction register, register file, ALU and dmem control.
- Reports a sticky fault when a memory access times out.

Parameters:
- WAIT_MAX, 16, maximum cycles a FETCH or MEM access may wait for ready before fault (≥2).
- CNT_W, 16, width of the retired-instruction counter (optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- opcode  in  4  IR[15:12], valid from DECODE onward
- Zero  in  1  ALU zero flag, combinational from current ALU op
- Negative  in  1  ALU negative flag
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- halt_req  in  1  request to stop at an instruction boundary
- ir_load  out  1  capture instruction word into IR
- pc_load  out  1  update PC this cycle
- pc_src  out  2  00 PC+1, 01 branch target, 10 jump target
- i_mem_oe  out  1  imem read enable
- rf_mux_sel  out  1  1 = rd write field (R-type), 0 = rt field
- rf_write_en  out  1  register file write
- alu_mux_sel  out  1  0 = register operand B, 1 = immediate
- alu_opcode  out  4  ALU operation
- d_mem_rw_  out  1  1 read, 0 write
- d_mem_cs  out  1  dmem chip select
- data_out_mux  out  1  1 = ALU result to RF, 0 = dmem data
- halted  out  1  FSM in HALT
- fault  out  1  sticky memory-timeout flag
- retired_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async): state=FETCH, wait counter=0, fault=0, retired_cnt=0. While rst=1, every output is 0 except rf_mux_sel=1 and data_out_mux=1.
- Default output values in any state: the reset values.
- Decode fields (held constant DECODE through WB):
  - alu_opcode = opcode for 0000–1000 and 1111; 0001 for branches 1001–1011; 0000 otherwise.
  - alu_mux_sel = 1 for 0100–1000, 1111, 1100, 1101.
  - rf_mux_sel = 1 only for 0000–0011.
  - data_out_mux = 0 only for Ld (1100).
- FETCH:
  - If halt_req=1 on entry cycle (wait count 0): go to HALT.
  - Else i_mem_oe=1. On imem_ready: ir_load=1, go to DECODE.
- HALT: halted=1, no memory activity. When halt_req=0, go to FETCH.
- DECODE (1 cycle):
  - Jump 1110: pc_load=1, pc_src=10, retire, go to FETCH.
  - All other opcodes: go to EXEC.
- EXEC:
  - Branches 1001/1010/1011: pc_load=1; pc_src=01 if taken, else 00; retire; go to FETCH.
    - Beq taken if Zero.
    - Blt taken if Negative.
    - Bgt taken if !Zero && !Negative.
    - Flags are sampled this cycle.
  - 1100/1101: go to MEM.
  - All others: go to WB.
- MEM:
  - d_mem_cs=1; d_mem_rw_=1 for Ld, 0 for St.
  - On dmem_ready: Ld goes to WB. St does pc_load=1, pc_src=00, retire, go to FETCH.
- WB (1 cycle): rf_write_en=1, pc_load=1, pc_src=00, retire, go to FETCH.
- Latency with zero-wait memory (ready in first cycle):
  - Jump 2 cycles.
  - Branch 3 cycles.
  - ALU op 4 cycles.
  - St 4 cycles.
  - Ld 5 cycles.
- Wait counter:
  - Counts cycles spent in FETCH or MEM without ready; clears on ready or state exit.
  - If count reaches WAIT_MAX-1 and ready is still 0: go to FAULT, fault=1.
  - Ready arriving on the last allowed cycle is accepted (no fault).
- FAULT: absorbing state, all controls at default. Left only by rst.
- halt_req is ignored outside the FETCH entry cycle; an in-flight instruction always completes.
- rst asserted mid-access: memory enables drop immediately (asynchronous); no partial RF write.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: retired_cnt increments by 1 on every retire event and saturates at all-ones.
- Undefined: retired_cnt is tied to 0 and the counter logic is absent.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode enum: OP_ADD..OP_ADDI, with values equal to the 4-bit encodings.
  - seq_state_t: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
  - pc_src_t: PC_INC, PC_BR, PC_JMP.
  - Constants ALU_SUB = 4'b0001 and ALU_ADD = 4'b0000.
- One sub-module: mem_wait_timer, with inputs clear/enable/ready and output expired, parameterised by WAIT_MAX.

Test Plan:
- Add (0000), imem_ready and dmem_ready always 1 → DECODE/EXEC/WB sequence; rf_write_en for exactly 1 cycle in WB; rf_mux_sel=1; pc_load=1 with pc_src=00 in cycle 4.
- Ld (1100), dmem_ready delayed 3 cycles → d_mem_cs=1 and d_mem_rw_=1 for 4 cycles; then WB with data_out_mux=0 and alu_mux_sel=1.
- Beq (1001) with Zero=1 → pc_src=01 in cycle 3. Same with Zero=0 → pc_src=00. Bgt with Zero=0, Negative=0 → taken.
- Jump (1110) → pc_load=1 with pc_src=10 in DECODE (cycle 2); no rf_write_en or d_mem_cs at any point.
- WAIT_MAX=4, imem_ready held 0 → fault=1 after 4 FETCH cycles; stays 1 with imem_ready=1 until rst. Ready on 4th cycle → no fault.
- halt_req=1 during an St → St completes, then halted=1. Release halt_req → FETCH. With SEQ_PERF_CNT_EN, retired_cnt=1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types, constants and decode helpers for the multi-cycle CPU control path.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_ANDI = 4'b0100,
    OP_ORI  = 4'b0101,
    OP_XORI = 4'b0110,
    OP_SLLI = 4'b0111,
    OP_SRLI = 4'b1000,
    OP_BEQ  = 4'b1001,
    OP_BLT  = 4'b1010,
    OP_BGT  = 4'b1011,
    OP_LD   = 4'b1100,
    OP_ST   = 4'b1101,
    OP_JMP  = 4'b1110,
    OP_ADDI = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pc_src_t;

  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0000;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGT);
  endfunction

  // Branches compare via subtraction; memory ops compute their address with an add.
  function automatic logic [3:0] dec_alu_op(input logic [3:0] op);
    logic [3:0] r;
    if ((op <= 4'b1000) || (op == OP_ADDI)) begin
      r = op;
    end else if (is_branch(op)) begin
      r = ALU_SUB;
    end else begin
      r = ALU_ADD;
    end
    return r;
  endfunction

  function automatic logic dec_uses_imm(input logic [3:0] op);
    return ((op >= OP_ANDI) && (op <= OP_SRLI)) || (op == OP_ADDI) ||
           (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic dec_is_rtype(input logic [3:0] op);
    return (op <= OP_OR);
  endfunction

  function automatic logic br_taken(input logic [3:0] op, input logic zero, input logic neg);
    logic t;
    case (op)
      OP_BEQ:  t = zero;
      OP_BLT:  t = neg;
      OP_BGT:  t = !zero && !neg;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory access waits for ready; flags expiry on the last allowed cycle.
module mem_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic expired
);

  localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on ready/clear/idle, otherwise advance up to LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable || ready) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !ready && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout fault.
// Optional retired-instruction counter enabled by macro SEQ_PERF_CNT_EN.
module multicycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             Zero,
  input  logic             Negative,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             ir_load,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             i_mem_oe,
  output logic             rf_mux_sel,
  output logic             rf_write_en,
  output logic             alu_mux_sel,
  output logic [3:0]       alu_opcode,
  output logic             d_mem_rw_,
  output logic             d_mem_cs,
  output logic             data_out_mux,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired_cnt
);

  seq_state_t state_q, state_d;
  logic       fetch_first_q, fetch_first_d;
  logic       fault_q, fault_d;
  logic       expired_s, timer_en_s, timer_clr_s, retire_s, halt_entry_s;

  logic       ir_load_s, pc_load_s, i_mem_oe_s, rf_mux_sel_s, rf_write_en_s;
  logic       alu_mux_sel_s, d_mem_rw_s, d_mem_cs_s, data_out_mux_s, halted_s;
  pc_src_t    pc_src_s;
  logic [3:0] alu_opcode_s;

  assign halt_entry_s = (state_q == FETCH) && fetch_first_q && halt_req;
  assign timer_en_s   = ((state_q == FETCH) && !halt_entry_s) || (state_q == MEM);
  assign timer_clr_s  = (state_d != state_q);

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr_s),
    .enable  (timer_en_s),
    .ready   ((state_q == MEM) ? dmem_ready : imem_ready),
    .expired (expired_s)
  );

  // Next-state and Mealy control outputs
  always_comb begin
    state_d        = state_q;
    retire_s       = 1'b0;
    ir_load_s      = 1'b0;
    pc_load_s      = 1'b0;
    pc_src_s       = PC_INC;
    i_mem_oe_s     = 1'b0;
    rf_mux_sel_s   = 1'b1;
    rf_write_en_s  = 1'b0;
    alu_mux_sel_s  = 1'b0;
    alu_opcode_s   = 4'b0000;
    d_mem_rw_s     = 1'b0;
    d_mem_cs_s     = 1'b0;
    data_out_mux_s = 1'b1;
    halted_s       = 1'b0;

    case (state_q)
      FETCH: begin
        if (halt_entry_s) begin
          state_d = HALT;
        end else begin
          i_mem_oe_s = 1'b1;
          if (imem_ready) begin
            ir_load_s = 1'b1;
            state_d   = DECODE;
          end else if (expired_s) begin
            state_d = FAULT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        halted_s = 1'b1;
        if (!halt_req) begin
          state_d = FETCH;
        end else begin
          state_d = HALT;
        end
      end
      DECODE: begin
        if (opcode == OP_JMP) begin
          pc_load_s = 1'b1;
          pc_src_s  = PC_JMP;
          retire_s  = 1'b1;
          state_d   = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_branch(opcode)) begin
          pc_load_s = 1'b1;
          pc_src_s  = br_taken(opcode, Zero, Negative) ? PC_BR : PC_INC;
          retire_s  = 1'b1;
          state_d   = FETCH;
        end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        d_mem_cs_s = 1'b1;
        d_mem_rw_s = (opcode == OP_LD);
        if (dmem_ready) begin
          if (opcode == OP_LD) begin
            state_d = WB;
          end else begin
            pc_load_s = 1'b1;
            pc_src_s  = PC_INC;
            retire_s  = 1'b1;
            state_d   = FETCH;
          end
        end else if (expired_s) begin
          state_d = FAULT;
        end else begin
          state_d = MEM;
        end
      end
      WB: begin
        rf_write_en_s = 1'b1;
        pc_load_s     = 1'b1;
        pc_src_s      = PC_INC;
        retire_s      = 1'b1;
        state_d       = FETCH;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase

    // Decode fields stay stable for the whole instruction after IR capture
    if ((state_q == DECODE) || (state_q == EXEC) || (state_q == MEM) || (state_q == WB)) begin
      alu_opcode_s   = dec_alu_op(opcode);
      alu_mux_sel_s  = dec_uses_imm(opcode);
      rf_mux_sel_s   = dec_is_rtype(opcode);
      data_out_mux_s = (opcode != OP_LD);
    end else begin
      alu_opcode_s   = 4'b0000;
      alu_mux_sel_s  = 1'b0;
      rf_mux_sel_s   = 1'b1;
      data_out_mux_s = 1'b1;
    end
  end

  // Fetch-entry flag and sticky fault next values
  always_comb begin
    fetch_first_d = (state_d == FETCH) && (state_q != FETCH);
    fault_d       = fault_q || (state_d == FAULT);
  end

  // State, fetch-entry and fault registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_first_q <= 1'b1;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_first_q <= fetch_first_d;
      fault_q       <= fault_d;
    end
  end

  // Reset forces controls to their idle values without waiting for a clock
  always_comb begin
    if (rst) begin
      ir_load      = 1'b0;
      pc_load      = 1'b0;
      pc_src       = 2'b00;
      i_mem_oe     = 1'b0;
      rf_mux_sel   = 1'b1;
      rf_write_en  = 1'b0;
      alu_mux_sel  = 1'b0;
      alu_opcode   = 4'b0000;
      d_mem_rw_    = 1'b0;
      d_mem_cs     = 1'b0;
      data_out_mux = 1'b1;
      halted       = 1'b0;
    end else begin
      ir_load      = ir_load_s;
      pc_load      = pc_load_s;
      pc_src       = pc_src_s;
      i_mem_oe     = i_mem_oe_s;
      rf_mux_sel   = rf_mux_sel_s;
      rf_write_en  = rf_write_en_s;
      alu_mux_sel  = alu_mux_sel_s;
      alu_opcode   = alu_opcode_s;
      d_mem_rw_    = d_mem_rw_s;
      d_mem_cs     = d_mem_cs_s;
      data_out_mux = data_out_mux_s;
      halted       = halted_s;
    end
  end

  assign fault = fault_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating retire count
  always_comb begin
    if (retire_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Retire counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;
`else
  logic unused_retire_s;
  assign unused_retire_s = retire_s;
  assign retired_cnt     = '0;
`endif

endmodule
